// File: rtl/gate_seq_ctrl.sv
// Stimulus sequencer and checker for the NOT / NAND / D flip-flop gate cells.
// Optional: define GATE_SEQ_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module gate_seq_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  output logic             in_not,
  output logic             in1_nand,
  output logic             in2_nand,
  output logic             D_flop,
  input  logic             out_not,
  input  logic             out_nand,
  input  logic             Q_flop,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       fail_vec
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       stim_q, stim_d;   // {D_flop, in1_nand, in2_nand, in_not}
  logic [CNT_W-1:0] err_q, err_d;
  logic [2:0]       fail_q, fail_d;
  logic             pass_q, pass_d;

  logic [2:0]       mm;
  logic [1:0]       mm_cnt;
  logic [CNT_W-1:0] err_add;
  logic             last_vec;

  function automatic logic [3:0] vec_stim(input logic [1:0] k);
    return {k[1] ^ k[0], k[1], k[0], k[0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Expected flop response is the D value being driven; it has been stable for the whole settle.
  assign mm[0]   = out_not  != ~idx_q[0];
  assign mm[1]   = out_nand != ~(idx_q[1] & idx_q[0]);
  assign mm[2]   = Q_flop   != stim_q[3];
  assign mm_cnt  = {1'b0, mm[0]} + {1'b0, mm[1]} + {1'b0, mm[2]};
  assign err_add = sat_add(err_q, mm_cnt);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign last_vec = (idx_q == 2'd3) || (mm != 3'b000);
`else
  assign last_vec = (idx_q == 2'd3);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          stim_d  = vec_stim(2'd0);
          cnt_d   = CW'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = CHECK;
      end
      CHECK: begin
        fail_d = fail_q | mm;
        err_d  = err_add;
        if (last_vec) begin
          stim_d  = '0;
          pass_d  = (err_add == '0);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          stim_d  = vec_stim(idx_q + 2'd1);
          cnt_d   = CW'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign in_not    = stim_q[0];
  assign in2_nand  = stim_q[1];
  assign in1_nand  = stim_q[2];
  assign D_flop    = stim_q[3];
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: two instances (CNT_W=4 and CNT_W=2) driving faultable gate-cell models.
module tb_gate_seq_ctrl;
  localparam int S = 2;

  logic clk = 1'b0, reset_L = 1'b0, start = 1'b0;
  int   mode = 0;  // 0 ideal, 1 NAND stuck-1, 2 NOT acts as buffer, 3 Q tied 0
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  logic a_not, a_in1, a_in2, a_d, a_onot, a_onand, a_q, a_busy, a_done, a_pass;
  logic [3:0] a_err;
  logic [2:0] a_fail;
  logic b_not, b_in1, b_in2, b_d, b_onot, b_onand, b_q, b_busy, b_done, b_pass;
  logic [1:0] b_err;
  logic [2:0] b_fail;
  logic a_ff = 1'b0, b_ff = 1'b0;

  gate_seq_ctrl #(.SETTLE_CYCLES(S), .CNT_W(4)) u_a (
    .clk(clk), .reset_L(reset_L), .start(start),
    .in_not(a_not), .in1_nand(a_in1), .in2_nand(a_in2), .D_flop(a_d),
    .out_not(a_onot), .out_nand(a_onand), .Q_flop(a_q),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err), .fail_vec(a_fail));

  gate_seq_ctrl #(.SETTLE_CYCLES(S), .CNT_W(2)) u_b (
    .clk(clk), .reset_L(reset_L), .start(start),
    .in_not(b_not), .in1_nand(b_in1), .in2_nand(b_in2), .D_flop(b_d),
    .out_not(b_onot), .out_nand(b_onand), .Q_flop(b_q),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err), .fail_vec(b_fail));

  always @(posedge clk) begin
    a_ff <= a_d;
    b_ff <= b_d;
  end
  assign a_onot  = (mode == 2) ? a_not : ~a_not;
  assign a_onand = (mode == 1) ? 1'b1 : ~(a_in1 & a_in2);
  assign a_q     = (mode == 3) ? 1'b0 : a_ff;
  assign b_onot  = (mode == 2) ? b_not : ~b_not;
  assign b_onand = (mode == 1) ? 1'b1 : ~(b_in1 & b_in2);
  assign b_q     = (mode == 3) ? 1'b0 : b_ff;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Mismatch bits {flop, nand, not} a faulty cell set produces on vector k.
  function automatic int mism(input int rm, input int k);
    int k1, k0, d, rn, rna, rq, r;
    k1 = k / 2; k0 = k % 2; d = k1 ^ k0;
    rn  = (rm == 2) ? k0 : 1 - k0;
    rna = (rm == 1) ? 1 : 1 - (k1 & k0);
    rq  = (rm == 3) ? 0 : d;
    r = 0;
    if (rn != 1 - k0) r |= 1;
    if (rna != 1 - (k1 & k0)) r |= 2;
    if (rq != d) r |= 4;
    return r;
  endfunction

  function automatic int nvec(input int rm);
    int v;
    v = 4;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    for (int k = 3; k >= 0; k--) if (mism(rm, k) != 0) v = k + 1;
`endif
    return v;
  endfunction

  // Expected outputs in cycle n of a run (n=0: nothing run since reset).
  function automatic void model(input int n, input int rm, input int cmax,
      output int e_not, output int e_in1, output int e_in2, output int e_d,
      output int e_busy, output int e_done, output int e_pass,
      output int e_err, output int e_fail);
    int p, v, k, m;
    p = S + 1; v = nvec(rm);
    e_not = 0; e_in1 = 0; e_in2 = 0; e_d = 0; e_busy = 0; e_done = 0;
    e_pass = 0; e_err = 0; e_fail = 0;
    if (n == 0) return;
    for (int j = 0; j < v; j++) begin
      if (n > (j + 1) * p) begin
        m = mism(rm, j);
        e_fail |= m;
        e_err += (m & 1) + ((m >> 1) & 1) + ((m >> 2) & 1);
        if (e_err > cmax) e_err = cmax;
      end
    end
    if (n <= v * p) begin
      k = (n - 1) / p;
      e_in1 = k / 2; e_in2 = k % 2; e_not = k % 2; e_d = (k / 2) ^ (k % 2);
      e_busy = 1;
    end else begin
      e_done = (n == v * p + 1) ? 1 : 0;
      e_pass = (e_err == 0) ? 1 : 0;
    end
  endfunction

  int mn = 0, run_mode = 0;
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) mn <= 0;
    else if (start && (mn == 0 || mn > nvec(run_mode) * (S + 1) + 1)) begin
      mn <= 1;
      run_mode <= mode;
    end else if (mn > 0) mn <= mn + 1;
  end

  always @(negedge clk) begin
    int en, e1, e2, ed, eb, edn, ep, ee, ef;
    model(mn, run_mode, 15, en, e1, e2, ed, eb, edn, ep, ee, ef);
    chk("a_in_not", a_not, en);  chk("a_in1_nand", a_in1, e1);
    chk("a_in2_nand", a_in2, e2); chk("a_D_flop", a_d, ed);
    chk("a_busy", a_busy, eb);   chk("a_done", a_done, edn);
    chk("a_pass", a_pass, ep);   chk("a_err_count", a_err, ee);
    chk("a_fail_vec", a_fail, ef);
    model(mn, run_mode, 3, en, e1, e2, ed, eb, edn, ep, ee, ef);
    chk("b_busy", b_busy, eb);   chk("b_done", b_done, edn);
    chk("b_D_flop", b_d, ed);    chk("b_pass", b_pass, ep);
    chk("b_err_count", b_err, ee); chk("b_fail_vec", b_fail, ef);
  end

  task automatic run_pulse(output int dc, output int bc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dc = -1; bc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (a_busy) bc++;
      if (a_done) begin dc = i; break; end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int dc, bc, nd, t1, t2;
    #12;
    chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0); chk("rst_pass", a_pass, 0);
    chk("rst_err", a_err, 0);   chk("rst_fail", a_fail, 0); chk("rst_D", a_d, 0);
    #10 reset_L = 1'b1;
    repeat (2) @(posedge clk);

    mode = 0; run_pulse(dc, bc);
    chk("s1_done_cycle", dc, 13); chk("s1_busy_cycles", bc, 12);
    chk("s1_err", a_err, 0); chk("s1_fail", a_fail, 0); chk("s1_pass", a_pass, 1);

    mode = 1; run_pulse(dc, bc);
    chk("s2_done_cycle", dc, 13); chk("s2_err", a_err, 1);
    chk("s2_fail", a_fail, 3'b010); chk("s2_pass", a_pass, 0);

    mode = 2; run_pulse(dc, bc);
    chk("s3_fail", a_fail, 3'b001); chk("s3_pass", a_pass, 0);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    chk("s3_done_cycle", dc, 4); chk("s3_err", a_err, 1); chk("s3_err_w2", b_err, 1);
`else
    chk("s3_done_cycle", dc, 13); chk("s3_err", a_err, 4); chk("s3_err_w2", b_err, 3);
`endif

    mode = 3; run_pulse(dc, bc);
    chk("s4_fail", a_fail, 3'b100);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    chk("s4_done_cycle", dc, 7); chk("s4_err", a_err, 1);
`else
    chk("s4_done_cycle", dc, 13); chk("s4_err", a_err, 2);
`endif

    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_done) nd++;
    end
    chk("s5_done_count", nd, 1);

    @(posedge clk); #1 start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (a_done) begin
        if (t1 < 0) t1 = i;
        else begin t2 = i; break; end
      end
    end
    start = 1'b0;
    if (t2 < 0) chk("s6_done_timeout", 0, 1);
    chk("s6_done_period", t2 - t1, 14);
    repeat (3) @(posedge clk);

    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(negedge clk);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    chk("s7_pre_err", a_err, 1);
`else
    chk("s7_pre_err", a_err, 2); chk("s7_pre_in1", a_in1, 1); chk("s7_pre_busy", a_busy, 1);
`endif
    #2 reset_L = 1'b0;
    #1;
    chk("s7_busy", a_busy, 0); chk("s7_in1", a_in1, 0); chk("s7_D", a_d, 0);
    chk("s7_err", a_err, 0);   chk("s7_fail", a_fail, 0); chk("s7_done", a_done, 0);
    repeat (2) @(negedge clk);
    #2 reset_L = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_done) nd++;
    end
    chk("s7_no_done", nd, 0);
    mode = 0; run_pulse(dc, bc);
    chk("s7_done_cycle", dc, 13); chk("s7_pass", a_pass, 1);
    chk("s7_err_after", a_err, 0); chk("s7_fail_after", a_fail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Self-checking stimulus sequencer for the gate library cells (NOT, NAND, D flip-flop). It steps the three cells under test through a fixed 4-entry vector table and waits a programmable settle time. It then compares the cell outputs against expected values and reports a sticky per-cell fail map, an error count and a pass flag. It replaces free-running `initial`-block stimulus with a synthesizable, restartable controller on the same `clk` as the cells.

## Interface
- `SETTLE_CYCLES`, 2: cycles between driving a vector and checking it; legal range is ≥1.
- `CNT_W`, 4: width of `err_count`; must be ≥2.

- `clk`  in  1  clock; drives this block and the D flip-flop under test.
- `reset_L`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled run request; accepted only in IDLE.
- `in_not`  out  1  NOT stimulus (registered).
- `in1_nand`  out  1  NAND input A stimulus (registered).
- `in2_nand`  out  1  NAND input B stimulus (registered).
- `D_flop`  out  1  flip-flop D stimulus (registered).
- `out_not`  in  1  NOT response.
- `out_nand`  in  1  NAND response.
- `Q_flop`  in  1  flip-flop response.
- `busy`  out  1  high in SETTLE and CHECK.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  registered in DONE; high when `err_count`==0; held until next accepted start.
- `err_count`  out  CNT_W  saturating count of mismatched output bits.
- `fail_vec`  out  3  sticky per-cell fail flags: [0] NOT, [1] NAND, [2] flop.

## Operation
- Vector index k = 0..3 (2-bit `idx`). Each vector drives: `in1_nand`=k[1], `in2_nand`=k[0], `in_not`=k[0], `D_flop`=k[1]^k[0].
- Expected values: `out_not`=~k[0]; `out_nand`=~(k[1]&k[0]); `Q_flop`=`D_flop` as currently driven. D is stable for ≥1 edge before the check.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: stimulus outputs are 0. If `start`=1 at an edge:
  - clear `err_count`, `fail_vec` and `pass`;
  - set `idx`=0 and drive vector 0;
  - load the settle counter with SETTLE_CYCLES;
  - go to SETTLE.
- SETTLE: decrement the counter each cycle. Go to CHECK on the edge where the counter is 1.
- CHECK: one cycle.
  - Compare the 3 responses against expected.
  - Each mismatching bit sets its `fail_vec` bit.
  - `err_count` adds the number of mismatched bits (0–3) and saturates at 2^CNT_W−1.
  - If `idx`==3, go to DONE. Otherwise increment `idx`, drive the next vector, reload the counter and go to SETTLE.
- DONE: one cycle. `done`=1; `pass` is registered from the final `err_count` (including the CHECK update just made). Stimulus outputs clear to 0. Next state is IDLE.
- `start` is ignored in SETTLE, CHECK and DONE. If `start` is held high continuously, a new run is accepted on the edge leaving IDLE right after DONE.

## Timing
- Reset (`reset_L`=0, asynchronous): state=IDLE; all outputs 0 (stimulus, `busy`, `done`, `pass`, `err_count`, `fail_vec`).
- Reset mid-run aborts immediately with no `done` pulse. After release, the block waits in IDLE for `start`.
- Cycle numbering: the start edge is E0; cycle 1 is the cycle after E0.
- Each vector takes SETTLE_CYCLES+1 cycles.
- CHECK for vector k occurs in cycle (k+1)(S+1).
- `busy` is high in cycles 1..4(S+1).
- `done` is high in cycle 4(S+1)+1, which is 13 for S=2.
- Stimulus changes only at clock edges, so responses are sampled at least S full cycles after the drive edge.

## Configuration
- `GATE_SEQ_STOP_ON_FAIL_EN` defined: a CHECK with any mismatch goes directly to DONE regardless of `idx`. Remaining vectors are skipped; `done` and `pass`(=0) are produced normally.
- Macro undefined: all 4 vectors always run.

## Test plan
- Ideal models, S=2, `start` pulse → `busy` high in cycles 1–12; `done` pulse in cycle 13; `pass`=1, `err_count`=0, `fail_vec`=3'b000.
- `out_nand` stuck at 1 → mismatch only at k=3; `err_count`=1, `fail_vec`=3'b010, `pass`=0.
- NOT replaced by a buffer → mismatch at all 4 vectors; `err_count`=4, `fail_vec`=3'b001. With CNT_W=2, `err_count` saturates at 3.
- `Q_flop` tied 0, macro undefined → mismatches at k=1 and k=2; `err_count`=2, `fail_vec`=3'b100, `done` in cycle 13.
  - Same fault with `GATE_SEQ_STOP_ON_FAIL_EN` → `done` in cycle 7, `err_count`=1.
- `start` pulsed again during SETTLE → ignored, single `done`. With `start` held high continuously, the second run's vector 0 is driven on the edge leaving IDLE (one cycle after DONE), and `done` pulses every 14 cycles.
- `reset_L` driven low during vector 2 SETTLE → all outputs 0 asynchronously, no `done`. After release and a new `start`, the full run passes as in the first scenario.
